// File: rtl/ps2_pkg.sv
// Shared PS/2 frame definitions: receiver FSM states, frame bit constants, parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

    // Parity bit that makes the total number of ones in data+parity odd.
    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_rx_sync_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on o_dout.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_din,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop on an empty FIFO is ignored; a push when full only lands if a pop frees a slot.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, frame FSM with timeout, scan-code FIFO.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_ps2_clk,
    input  logic                   i_ps2_data,
    output logic [7:0]             o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_overflow,
    output logic                   o_parity_err,
    output logic                   o_frame_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    logic [2:0]           r_clk_sync;
    logic [1:0]           r_data_sync;
    ps2_state_e           r_state;
    ps2_state_e           w_state_nxt;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 w_par_nxt;
    logic [TW-1:0]        r_tmo_cnt;
    logic                 r_overflow;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 w_edge;
    logic                 w_bit;
    logic                 w_timeout;
    logic                 w_push;
    logic                 w_perr;
    logic                 w_ferr;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    // Flops reset to 1 so the idle bus does not look like a falling edge out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= 3'b111;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
        end
    end

    assign w_edge    = !r_clk_sync[1] && r_clk_sync[2];
    assign w_bit     = r_data_sync[1];
    assign w_timeout = (r_tmo_cnt == TMO_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_push        = 1'b0;
        w_perr        = 1'b0;
        w_ferr        = 1'b0;
        if (w_timeout) begin
            w_state_nxt = IDLE;
            w_ferr      = 1'b1;
        end else if (w_edge) begin
            case (r_state)
                IDLE: begin
                    if (w_bit == START_BIT) begin
                        w_state_nxt   = DATA;
                        w_bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    w_shift_nxt   = {w_bit, r_shift[DATA_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'(DATA_BITS - 1)) w_state_nxt = PARITY;
                end
                PARITY: begin
                    w_par_nxt   = w_bit;
                    w_state_nxt = STOP;
                end
                STOP: begin
                    // A bad stop bit masks any parity problem in the same frame.
                    if (w_bit != STOP_BIT)                  w_ferr = 1'b1;
                    else if (odd_parity(r_shift) != r_par) w_perr = 1'b1;
                    else                                    w_push = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_state == IDLE || w_edge || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_pop = i_ready && o_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_overflow   <= r_overflow | (w_push && w_full && !w_pop);
            r_parity_err <= w_perr;
            r_frame_err  <= w_ferr;
        end
    end

    sync_fifo #(
        .W     (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_pop   (i_ready),
        .i_din   (r_shift),
        .o_dout  (o_data),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_valid      = !w_empty;
    assign o_overflow   = r_overflow;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: frames driven on the pins, hand-computed expected bytes and flags.
module tb_ps2_rx;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_ps2_clk = 1'b1;
    logic       i_ps2_data = 1'b1;
    logic       i_ready = 1'b0;
    logic [7:0] o_data;
    logic       o_valid;
    logic [3:0] o_count;
    logic       o_overflow;
    logic       o_parity_err;
    logic       o_frame_err;

    int         n_chk = 0;
    int         n_fail = 0;
    int         perr_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] last_pop = 8'h00;

    ps2_rx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_ps2_clk    (i_ps2_clk),
        .i_ps2_data   (i_ps2_data),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_count      (o_count),
        .o_overflow   (o_overflow),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Each cycle an error flag is high counts once, so a stretched pulse shows up as an extra count.
    always @(negedge i_clk) begin
        if (o_parity_err) perr_cnt++;
        if (o_frame_err)  ferr_cnt++;
        if (o_valid && i_ready) last_pop = o_data;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        i_ps2_data = b;
        repeat (HALF) @(posedge i_clk);
        i_ps2_clk = 1'b0;
        repeat (HALF) @(posedge i_clk);
        i_ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stp);
        i_ps2_data = 1'b1;
        repeat (10) @(negedge i_clk);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        @(negedge i_clk);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk(tag, 32'(o_data), 32'(exp));
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    initial begin
        int p0;
        int f0;
        logic [7:0] bytes [9];
        logic       pars  [9];
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        pars  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_ovf", 32'(o_overflow), 0);
        chk("rst_perr", 32'(o_parity_err), 0);
        chk("rst_ferr", 32'(o_frame_err), 0);
        i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);

        // Single good frame, consumer stalled
        send(8'h1C, 1'b0, 1'b1);
        chk("f1c_count", 32'(o_count), 1);
        chk("f1c_perr_cnt", 32'(perr_cnt), 0);
        chk("f1c_ferr_cnt", 32'(ferr_cnt), 0);
        pop("f1c_data", 8'h1C);
        chk("f1c_empty", 32'(o_valid), 0);
        chk("f1c_count0", 32'(o_count), 0);

        // Ordering across two frames
        send(8'hF0, 1'b1, 1'b1);
        pop("ord_f0", 8'hF0);
        send(8'h1C, 1'b0, 1'b1);
        pop("ord_1c", 8'h1C);
        chk("ord_count", 32'(o_count), 0);

        // Parity error, then recovery
        send(8'h1C, 1'b1, 1'b1);
        chk("perr_cnt", 32'(perr_cnt), 1);
        chk("perr_count", 32'(o_count), 0);
        send(8'h5A, 1'b1, 1'b1);
        chk("perr_rec_count", 32'(o_count), 1);
        pop("perr_rec_data", 8'h5A);

        // Bad stop bit, and bad stop with bad parity (stop wins)
        send(8'h5A, 1'b1, 1'b0);
        chk("stop_ferr", 32'(ferr_cnt), 1);
        send(8'h5A, 1'b0, 1'b0);
        chk("stop_ferr2", 32'(ferr_cnt), 2);
        chk("stop_perr", 32'(perr_cnt), 1);
        chk("stop_count", 32'(o_count), 0);

        // ready held high: byte passes straight through
        i_ready = 1'b1;
        send(8'h77, 1'b1, 1'b1);
        chk("rdy_last", 32'(last_pop), 32'h77);
        chk("rdy_count", 32'(o_count), 0);
        i_ready = 1'b0;

        // Fill to DEPTH, ninth byte dropped
        for (int i = 0; i < 8; i++) send(bytes[i], pars[i], 1'b1);
        chk("full_count", 32'(o_count), 8);
        chk("full_ovf0", 32'(o_overflow), 0);
        send(bytes[8], pars[8], 1'b1);
        chk("ovf_count", 32'(o_count), 8);
        chk("ovf_flag", 32'(o_overflow), 1);
        for (int i = 0; i < 8; i++) pop($sformatf("drain%0d", i), bytes[i]);
        chk("drain_count", 32'(o_count), 0);
        chk("drain_valid", 32'(o_valid), 0);
        chk("drain_ovf", 32'(o_overflow), 1);

        // Timeout after start + 4 data bits
        p0 = perr_cnt;
        f0 = ferr_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        repeat (TIMEOUT + 10) @(posedge i_clk);
        @(negedge i_clk);
        chk("tmo_ferr", 32'(ferr_cnt - f0), 1);
        chk("tmo_perr", 32'(perr_cnt - p0), 0);
        chk("tmo_count", 32'(o_count), 0);
        send(8'h5A, 1'b1, 1'b1);
        chk("tmo_rec_count", 32'(o_count), 1);
        chk("tmo_rec_data", 32'(o_data), 32'h5A);

        // Reset in mid-frame with a byte still queued
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(o_valid), 0);
        chk("mrst_data", 32'(o_data), 0);
        chk("mrst_count", 32'(o_count), 0);
        chk("mrst_ovf", 32'(o_overflow), 0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        send(8'h29, 1'b0, 1'b1);
        chk("post_valid", 32'(o_valid), 1);
        chk("post_data", 32'(o_data), 32'h29);
        chk("post_count", 32'(o_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
